// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the MEM stage and its pipeline register.
//   DATA_W     : datapath width
//   REG_AW     : register-file address width
//   WB_SEL_MEM : writeback-select code that picks load data
//   mem_state_t: MEM stage FSM states
package cpu_pkg;
  localparam int         DATA_W     = 16;
  localparam int         REG_AW     = 3;
  localparam logic [1:0] WB_SEL_MEM = 2'd2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with load enable and synchronous clear.
//   clk        : clock
//   i_clr      : synchronous clear of every field
//   i_ld       : load the slot; when low the slot becomes a bubble
//   i_ld_mdat  : load the memory-data field (loads only)
//   i_valid, i_rwe, i_raddr, i_ctl, i_dat, i_mdat : slot contents
//   o_*        : registered slot contents
module mem_wb_reg
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              i_clr,
  input  logic              i_ld,
  input  logic              i_ld_mdat,
  input  logic              i_valid,
  input  logic              i_rwe,
  input  logic [REG_AW-1:0] i_raddr,
  input  logic [1:0]        i_ctl,
  input  logic [DATA_W-1:0] i_dat,
  input  logic [DATA_W-1:0] i_mdat,
  output logic              o_valid,
  output logic              o_rwe,
  output logic [REG_AW-1:0] o_raddr,
  output logic [1:0]        o_ctl,
  output logic [DATA_W-1:0] o_dat,
  output logic [DATA_W-1:0] o_mdat
);

  logic              r_valid;
  logic              r_rwe;
  logic [REG_AW-1:0] r_raddr;
  logic [1:0]        r_ctl;
  logic [DATA_W-1:0] r_dat;
  logic [DATA_W-1:0] r_mdat;

  // Valid and write enable drop to 0 whenever the slot is not loaded, so a
  // stalled cycle always presents a bubble; the data fields simply hold.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_valid <= 1'b0;
      r_rwe   <= 1'b0;
      r_raddr <= '0;
      r_ctl   <= '0;
      r_dat   <= '0;
      r_mdat  <= '0;
    end else begin
      r_valid <= i_ld & i_valid;
      r_rwe   <= i_ld & i_rwe;
      if (i_ld) begin
        r_raddr <= i_raddr;
        r_ctl   <= i_ctl;
        r_dat   <= i_dat;
      end
      if (i_ld_mdat) r_mdat <= i_mdat;
    end
  end

  assign o_valid = r_valid;
  assign o_rwe   = r_rwe;
  assign o_raddr = r_raddr;
  assign o_ctl   = r_ctl;
  assign o_dat   = r_dat;
  assign o_mdat  = r_mdat;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues loads/stores to a handshaked memory, stalls the
// upstream pipeline until mem_ack, and feeds the MEM/WB register.
//   clk, rst_n            : clock, synchronous active-low reset
//   valid_mem .. regwrite_dat_controll_mem : EX/MEM slot inputs
//   mem_req, mem_we, mem_addr, mem_wdata   : memory request side
//   mem_rdata, mem_ack                     : memory response side
//   stall_mem             : freezes all upstream stages
//   valid_wb .. main_mem_dat_wb            : MEM/WB slot outputs
//   mem_err               : sticky timeout flag
module mem_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int AW      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_mem,
  input  logic [DATA_W-1:0] alu_res_mem,
  input  logic [DATA_W-1:0] store_dat_mem,
  input  logic              mem_read_mem,
  input  logic              mem_write_mem,
  input  logic              regwrite_en_mem,
  input  logic [REG_AW-1:0] regwrite_addr_mem,
  input  logic [1:0]        regwrite_dat_controll_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_mem,
  output logic              valid_wb,
  output logic              regwrite_en_wb,
  output logic [REG_AW-1:0] regwrite_addr_wb,
  output logic [1:0]        regwrite_dat_controll_wb,
  output logic [DATA_W-1:0] regwrite_dat_wb,
  output logic [DATA_W-1:0] main_mem_dat_wb,
  output logic              mem_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_state_t        r_state;
  logic [7:0]        r_cnt;
  logic              r_err;
  logic              r_rst_blk;  // high for the first cycle after reset

  // Request captured at issue; drives the memory bus and writeback in WAIT.
  logic              r_we;
  logic [AW-1:0]     r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_alu;
  logic              r_rwe;
  logic [REG_AW-1:0] r_raddr;
  logic [1:0]        r_ctl;

  logic              w_memop;
  logic              w_ok;
  logic              w_start;
  logic              w_wait;
  logic              w_ack;
  logic              w_tmo;

  logic              w_ld;
  logic              w_ld_mdat;
  logic              w_valid;
  logic              w_rwe;
  logic [REG_AW-1:0] w_raddr;
  logic [1:0]        w_ctl;
  logic [DATA_W-1:0] w_dat;

  assign w_memop = mem_read_mem | mem_write_mem;
  // No request or stall is raised in reset or in the cycle right after it.
  assign w_ok    = rst_n & ~r_rst_blk;
  assign w_start = w_ok & (r_state == S_IDLE) & valid_mem & w_memop;
  assign w_wait  = w_ok & (r_state == S_WAIT);
  assign w_ack   = w_wait & mem_ack;
  assign w_tmo   = w_wait & ~mem_ack & (r_cnt == CNT_LAST);

  assign mem_req   = w_start | w_wait;
  // Read+write together is treated as a store.
  assign mem_we    = w_start ? mem_write_mem : (w_wait & r_we);
  assign mem_addr  = (r_state == S_WAIT) ? r_addr  : AW'(alu_res_mem);
  assign mem_wdata = (r_state == S_WAIT) ? r_wdata : store_dat_mem;
  assign stall_mem = w_start | (w_wait & ~mem_ack);
  assign mem_err   = r_err;

  // MEM/WB load selection: pass-through for non-memory ops in IDLE, captured
  // request on ack/timeout in WAIT, bubble otherwise.
  always_comb begin
    w_ld      = 1'b0;
    w_ld_mdat = 1'b0;
    w_valid   = valid_mem;
    w_rwe     = valid_mem & regwrite_en_mem;
    w_raddr   = regwrite_addr_mem;
    w_ctl     = regwrite_dat_controll_mem;
    w_dat     = alu_res_mem;
    if (r_state == S_WAIT) begin
      w_ld      = w_ack | w_tmo;
      w_ld_mdat = w_ack & ~r_we;
      w_valid   = 1'b1;
      w_rwe     = r_rwe & ~r_we & ~w_tmo;
      w_raddr   = r_raddr;
      w_ctl     = r_ctl;
      w_dat     = r_alu;
    end else begin
      w_ld = ~(valid_mem & w_memop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_rst_blk <= 1'b1;
    end else begin
      r_rst_blk <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (w_ack || w_tmo) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            if (w_tmo) r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_we    <= mem_write_mem;
      r_addr  <= AW'(alu_res_mem);
      r_wdata <= store_dat_mem;
      r_alu   <= alu_res_mem;
      r_rwe   <= regwrite_en_mem;
      r_raddr <= regwrite_addr_mem;
      r_ctl   <= regwrite_dat_controll_mem;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk       (clk),
    .i_clr     (~rst_n),
    .i_ld      (w_ld),
    .i_ld_mdat (w_ld_mdat),
    .i_valid   (w_valid),
    .i_rwe     (w_rwe),
    .i_raddr   (w_raddr),
    .i_ctl     (w_ctl),
    .i_dat     (w_dat),
    .i_mdat    (mem_rdata),
    .o_valid   (valid_wb),
    .o_rwe     (regwrite_en_wb),
    .o_raddr   (regwrite_addr_wb),
    .o_ctl     (regwrite_dat_controll_wb),
    .o_dat     (regwrite_dat_wb),
    .o_mdat    (main_mem_dat_wb)
  );

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: TIMEOUT, default 255, max cycles to wait for mem_ack; AW, default 16, memory address width.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  sole clock, all state updates on its rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 valid_mem  in  1  EX/MEM slot holds an instruction.
REQ-006 alu_res_mem  in  16  ALU result; used as the memory address for loads and stores.
REQ-007 store_dat_mem  in  16  store data.
REQ-008 mem_read_mem / mem_write_mem  in  1 each  load / store request; both set is illegal and is treated as a store.
REQ-009 regwrite_en_mem  in  1  destination register write enable.
REQ-010 regwrite_addr_mem  in  3  destination register.
REQ-011 regwrite_dat_controll_mem  in  2  writeback select; code 2 selects memory data.
REQ-012 mem_req / mem_we  out  1 each  memory request / write strobe.
REQ-013 mem_addr  out  AW  address; mem_wdata  out  16  write data.
REQ-014 mem_rdata  in  16  read data, valid when mem_ack=1.
REQ-015 mem_ack  in  1  completes the outstanding request.
REQ-016 stall_mem  out  1  freezes all upstream stages.
REQ-017 valid_wb, regwrite_en_wb  out  1 each  MEM/WB slot valid / write enable.
REQ-018 regwrite_addr_wb  out  3; regwrite_dat_controll_wb  out  2.
REQ-019 regwrite_dat_wb, main_mem_dat_wb  out  16  ALU result and load data registered for writeback.
REQ-020 mem_err  out  1  sticky timeout flag.

Function
REQ-021 The FSM SHALL have states IDLE and WAIT.
REQ-022 In IDLE, a valid non-memory instruction SHALL be registered into MEM/WB on the next edge with 1-cycle latency; main_mem_dat_wb is held unchanged.
REQ-023 In IDLE, a valid load/store SHALL assert mem_req combinationally, assert stall_mem, and enter WAIT at the next edge.
REQ-024 In WAIT, mem_req, mem_we, mem_addr and mem_wdata SHALL be held stable, driven from captured copies.
REQ-025 stall_mem = (IDLE and valid_mem and memop) or (WAIT and not mem_ack).
REQ-026 On mem_ack in WAIT, the MEM/WB registers SHALL be loaded at that edge, main_mem_dat_wb SHALL take mem_rdata for a load, and the FSM SHALL return to IDLE.
REQ-027 A store retires with valid_wb=1 and regwrite_en_wb=0.
REQ-028 An instruction SHALL NOT retire before it completes: while stall_mem=1, valid_wb SHALL be 0 each cycle (bubble insertion).
REQ-029 mem_ack seen in IDLE SHALL be ignored.
REQ-030 A wait counter (8 bits) SHALL increment in WAIT. When it reaches TIMEOUT without ack:
  - mem_err is set;
  - the instruction retires with regwrite_en_wb=0;
  - the FSM returns to IDLE.
REQ-031 Back-to-back memory ops SHALL each pay a minimum of 2 cycles; a zero-wait memory (ack in the first WAIT cycle) gives exactly 2 cycles per op.

Reset
REQ-032 While rst_n=0 at an edge, the block SHALL enter IDLE.
REQ-033 Reset clears: wait counter, mem_err, valid_wb, regwrite_en_wb, and all _wb data fields (to 0).
REQ-034 mem_req and stall_mem SHALL be 0 while in reset and during the cycle after it.
REQ-035 Reset during WAIT SHALL abandon the request with no retirement; a late mem_ack after reset SHALL be ignored.

Structure
REQ-036 A shared cpu_pkg holds:
  - the wb-select constant WB_SEL_MEM = 2;
  - the register-address width (3);
  - the data width (16);
  - the mem_state_t enum.
REQ-037 One sub-module, mem_wb_reg (the MEM/WB pipeline register with load enable and sync clear), SHALL be instantiated; the FSM stays in mem_stage.

Verification
REQ-038 ALU op: valid_mem=1, alu_res=0x1234, regwrite_en=1, addr=3 -> next cycle valid_wb=1, regwrite_dat_wb=0x1234, regwrite_addr_wb=3, stall_mem never 1.
REQ-039 Load, ack after 3 cycles: addr 0x0040, mem_rdata=0xBEEF -> mem_req held 4 cycles, stall_mem=1 for 3 cycles, then main_mem_dat_wb=0xBEEF, ctl_wb=2, valid_wb pulses once.
REQ-040 Store with zero-wait ack: addr 0x0010, data 0x00FF -> mem_we=1, mem_wdata=0x00FF, retire 2 cycles later with regwrite_en_wb=0.
REQ-041 Timeout, TIMEOUT=4, ack never arrives -> mem_err=1 after 4 WAIT cycles, retire with regwrite_en_wb=0, FSM back in IDLE, mem_err stays 1.
REQ-042 Reset in WAIT: rst_n=0 in the second WAIT cycle, then ack the next cycle -> IDLE, valid_wb=0, no retirement, mem_req=0.
REQ-043 Back-to-back loads A then B with zero-wait ack -> retire order A then B, 2 cycles apart, data correct.
